// File: rtl/fifo_axi_burst_sched.sv
// rtl/fifo_axi_burst_sched.sv - read-side FIFO drain into aligned AXI4 write bursts
// Optional partial-burst flush on idle timeout: define FLUSH_TIMEOUT_EN.
module fifo_axi_burst_sched #(
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        ADDR_WIDTH     = 4,
    parameter int                        BURST_LEN      = 8,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        REGION_BYTES   = 4096,
    parameter int                        TIMEOUT        = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH:0]         wptr_gray_sync,
    output logic [ADDR_WIDTH:0]         rptr_gray,
    output logic [ADDR_WIDTH-1:0]       fifo_raddr,
    input  logic [DATA_WIDTH-1:0]       fifo_rdata,
    output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH/8-1:0]     wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic                        busy,
    output logic                        err
);
    localparam int PW        = ADDR_WIDTH + 1;
    localparam int BW        = $clog2(BURST_LEN) + 1;
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BYTE_SH   = $clog2(BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] REGION_END = BASE_ADDR + AXI_ADDR_WIDTH'(REGION_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_cur_q, addr_cur_d;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [7:0]                  awlen_q, awlen_d;
    logic [BW-1:0]               beats_q, beats_d;
    logic [BW-1:0]               remain_q, remain_d;
    logic [PW-1:0]               rbin_q, rbin_d;
    logic [PW-1:0]               rgray_q, rgray_d;
    logic                        err_q, err_d;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [PW-1:0]             wbin;
    logic [PW-1:0]             count;
    logic [AXI_ADDR_WIDTH-1:0] addr_words;
    logic [BW-1:0]             room;
    logic                      enough;
    logic                      partial;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;
    logic                      flush;

    assign wbin       = gray2bin(wptr_gray_sync);
    assign count      = wbin - rbin_q;
    assign addr_words = addr_cur_q >> BYTE_SH;
    // Beats remaining up to the next BURST_LEN-aligned boundary; bursts never straddle it.
    assign room       = BW'(BURST_LEN) - BW'(addr_words % AXI_ADDR_WIDTH'(BURST_LEN));
    assign enough     = 32'(count) >= 32'(room);
    assign partial    = (count != '0) && !enough;
    assign addr_next  = addr_cur_q + (AXI_ADDR_WIDTH'(beats_q) << BYTE_SH);

`ifdef FLUSH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;

    assign flush = partial && (32'(idle_cnt_q) >= TIMEOUT);

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == S_IDLE && partial && !flush) idle_cnt_d = idle_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_cnt_q <= '0;
        else      idle_cnt_q <= idle_cnt_d;
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign flush = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_cur_d = addr_cur_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        beats_d    = beats_q;
        remain_d   = remain_q;
        rbin_d     = rbin_q;
        rgray_d    = rgray_q;
        err_d      = err_q;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enough || flush) begin
                    beats_d  = enough ? room : BW'(count);
                    remain_d = beats_d;
                    awaddr_d = addr_cur_q;
                    awlen_d  = 8'(beats_d) - 8'd1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                awvalid = 1'b1;
                if (awready) state_d = S_DATA;
            end
            S_DATA: begin
                wvalid = 1'b1;
                wlast  = (remain_q == BW'(1));
                if (wready) begin
                    rbin_d   = rbin_q + 1'b1;
                    rgray_d  = rbin_d ^ (rbin_d >> 1);
                    remain_d = remain_q - 1'b1;
                    if (wlast) state_d = S_RESP;
                end
            end
            S_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_d      = err_q | (bresp != 2'b00);
                    addr_cur_d = (addr_next == REGION_END) ? BASE_ADDR : addr_next;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_cur_q <= BASE_ADDR;
            awaddr_q   <= BASE_ADDR;
            awlen_q    <= '0;
            beats_q    <= '0;
            remain_q   <= '0;
            rbin_q     <= '0;
            rgray_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cur_q <= addr_cur_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            beats_q    <= beats_d;
            remain_q   <= remain_d;
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            err_q      <= err_d;
        end
    end

    assign rptr_gray  = rgray_q;
    assign fifo_raddr = rbin_q[ADDR_WIDTH-1:0];
    assign awaddr     = awaddr_q;
    assign awlen      = awlen_q;
    assign awsize     = 3'(BYTE_SH);
    assign awburst    = 2'b01;
    assign wdata      = fifo_rdata;
    assign wstrb      = '1;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
endmodule

// File: tb/tb_fifo_axi_burst_sched.sv
// tb/tb_fifo_axi_burst_sched.sv - scoreboard bench for fifo_axi_burst_sched
module tb_fifo_axi_burst_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wptr_gray_sync;
    logic [4:0]  rptr_gray;
    logic [3:0]  fifo_raddr;
    logic [31:0] fifo_rdata;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready, busy, err;

    logic [31:0] mem [16];
    logic [31:0] aw_q[$];
    logic [7:0]  awlen_q[$];
    logic [31:0] data_q[$];
    logic        wlast_q[$];
    logic [4:0]  wbin;
    logic [31:0] seq;
    logic        wr_toggle;
    int          checks, fails;
    logic [4:0]  exp_rptr;

    fifo_axi_burst_sched dut (
        .clk(clk), .rst(rst), .wptr_gray_sync(wptr_gray_sync), .rptr_gray(rptr_gray),
        .fifo_raddr(fifo_raddr), .fifo_rdata(fifo_rdata), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy), .err(err)
    );

    assign fifo_rdata = mem[fifo_raddr];
    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wbin[3:0]] = 32'hC0DE_0000 + seq;
            data_q.push_back(32'hC0DE_0000 + seq);
            seq++;
            wbin++;
        end
        wptr_gray_sync = to_gray(wbin);
    endtask

    task automatic expect_burst(input logic [31:0] addr, input int beats);
        aw_q.push_back(addr);
        awlen_q.push_back(8'(beats - 1));
        for (int i = 1; i <= beats; i++) wlast_q.push_back(i == beats);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((aw_q.size() != 0 || data_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL %s: timeout, aw pending %0d data pending %0d required 0", name, aw_q.size(), data_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (awvalid && awready) begin
                if (aw_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL aw_unexpected: got awaddr 0x%0h required no burst", awaddr);
                end else begin
                    check("awaddr", awaddr, aw_q.pop_front());
                    check("awlen", 32'(awlen), 32'(awlen_q.pop_front()));
                    check("awsize_awburst", {27'd0, awsize, awburst}, 32'b010_01);
                end
            end
            if (wvalid) begin
                if (data_q.size() == 0 || wlast_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL w_unexpected: got wdata 0x%0h required no beat", wdata);
                end else if (wready) begin
                    check("wdata", wdata, data_q.pop_front());
                    check("wlast", 32'(wlast), 32'(wlast_q.pop_front()));
                    check("wstrb", 32'(wstrb), 32'hF);
                end else begin
                    check("wdata_stall", wdata, data_q[0]);
                end
            end
        end
    end

    initial begin
        wready = 1'b1;
        forever begin
            @(posedge clk); #1;
            wready = wr_toggle ? ~wready : 1'b1;
        end
    end

    initial begin
        checks = 0; fails = 0; seq = 0; wbin = 0; wr_toggle = 1'b0;
        rst = 1'b0; wptr_gray_sync = '0; awready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #12;
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_wlast", 32'(wlast), 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", 32'(awlen), 0);
        check("rst_rptr", 32'(rptr_gray), 0);
        check("rst_raddr", 32'(fifo_raddr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        expect_burst(32'h0, 8);
        write_words(8);
        wait_idle("burst8");
        check("rptr_after_8", 32'(rptr_gray), 32'(5'b01100));

        wr_toggle = 1'b1;
        expect_burst(32'h20, 8);
        expect_burst(32'h40, 8);
        write_words(16);
        wait_idle("burst16_stall");
        wr_toggle = 1'b0;
        check("rptr_after_24", 32'(rptr_gray), 32'(5'b10100));

        bresp = 2'b10;
        expect_burst(32'h60, 8);
        write_words(8);
        wait_idle("slverr");
        bresp = 2'b00;
        check("err_set", 32'(err), 1);
        expect_burst(32'h80, 8);
        write_words(8);
        wait_idle("after_err");
        check("err_sticky", 32'(err), 1);

`ifdef FLUSH_TIMEOUT_EN
        expect_burst(32'hA0, 3);
        exp_rptr = 5'd11;
`else
        exp_rptr = 5'd8;
`endif
        write_words(3);
        repeat (100) @(posedge clk);
        #1;
        check("partial_busy", 32'(busy), 0);
        check("partial_rptr", 32'(rptr_gray), 32'(to_gray(exp_rptr)));
`ifdef FLUSH_TIMEOUT_EN
        expect_burst(32'hAC, 5);
`else
        expect_burst(32'hA0, 8);
`endif
        write_words(5);
        wait_idle("partial_complete");

        for (int i = 0; i < 122; i++) begin
            expect_burst(32'hC0 + 32'(i) * 32'h20, 8);
            write_words(8);
            wait_idle("region_fill");
        end
        expect_burst(32'h0, 8);
        write_words(8);
        wait_idle("region_wrap");

        expect_burst(32'h20, 8);
        write_words(8);
        begin
            int n = 0;
            while (!wvalid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("reset_wvalid_seen", 32'(wvalid), 1);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        aw_q.delete(); awlen_q.delete(); data_q.delete(); wlast_q.delete();
        #1;
        check("midrst_wvalid", 32'(wvalid), 0);
        check("midrst_rptr", 32'(rptr_gray), 0);
        check("midrst_raddr", 32'(fifo_raddr), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_awaddr", awaddr, 0);
        wbin = '0;
        wptr_gray_sync = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        expect_burst(32'h0, 8);
        write_words(8);
        wait_idle("after_reset");
        check("rptr_after_reset", 32'(rptr_gray), 32'(5'b01100));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
